// File: rtl/fir_tap_loader.sv
// Shadow coefficient RAM plus a commit sequencer that streams all NTAPS
// coefficients, highest index first, into a downstream FIR's serial tap chain.
module fir_tap_loader #(
    parameter int NTAPS   = 128,
    parameter int TW      = 12,
    parameter int LGNTAPS = 7
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wr,
    input  logic [LGNTAPS-1:0] i_addr,
    input  logic [TW-1:0]      i_data,
    input  logic               i_commit,
    output logic [TW-1:0]      o_rdata,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_tap_wr,
    output logic [TW-1:0]      o_tap,
    output logic [1:0]         o_state
);

    // Commit handshake: i_commit is a request that is taken only in a cycle
    // where o_busy is low (o_done cycle included); requests seen while o_busy
    // is high are dropped, never queued. Host writes obey the same o_busy gate.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [LGNTAPS-1:0] counter, counter_nxt;
    logic [TW-1:0]      ram [NTAPS];
    logic               in_range;

    assign in_range = int'(i_addr) < NTAPS;
    assign o_busy   = (state != IDLE);
    assign o_state  = state;

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        case (state)
            IDLE: begin
                if (i_commit) begin
                    state_nxt   = READ;
                    counter_nxt = LGNTAPS'(NTAPS - 1);
                end
            end
            READ: begin
                // Counter stops at zero, so it never wraps.
                if (counter == '0) state_nxt = DRAIN;
                else               counter_nxt = counter - LGNTAPS'(1);
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && i_wr && !o_busy && in_range)
            ram[i_addr] <= i_data;
    end

    // The tap strobe trails READ by one cycle because the RAM read is registered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_tap_wr <= 1'b0;
            o_tap    <= '0;
            o_done   <= 1'b0;
            o_rdata  <= '0;
        end else begin
            o_tap_wr <= (state == READ);
            if (state == READ)
                o_tap <= ram[counter];
            o_done   <= (state == DRAIN);
            o_rdata  <= in_range ? ram[i_addr] : '0;
        end
    end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Bench for fir_tap_loader: cycle-indexed reference model, directed burst checks
// with literal expectations, and a randomized phase.
module tb_fir_tap_loader;
  localparam int NTAPS = 8;
  localparam int TW    = 12;
  localparam int LG    = 4;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_wr = 1'b0;
  logic [LG-1:0] i_addr = '0;
  logic [TW-1:0] i_data = '0;
  logic          i_commit = 1'b0;
  logic [TW-1:0] o_rdata;
  logic          o_busy;
  logic          o_done;
  logic          o_tap_wr;
  logic [TW-1:0] o_tap;
  logic [1:0]    o_state;

  int n_cmp = 0;
  int n_err = 0;

  fir_tap_loader #(.NTAPS(NTAPS), .TW(TW), .LGNTAPS(LG)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_wr(i_wr), .i_addr(i_addr),
    .i_data(i_data), .i_commit(i_commit), .o_rdata(o_rdata), .o_busy(o_busy),
    .o_done(o_done), .o_tap_wr(o_tap_wr), .o_tap(o_tap), .o_state(o_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Cycle k is the interval after posedge k; a commit accepted in cycle c0 gives
  // busy in [c0+1, c0+N+1], tap_wr in [c0+2, c0+N+1], done at c0+N+2.
  int            cyc = 0;
  int            c0 = 0;
  int            n;
  bit            active = 0;
  bit            busy_now;
  logic [TW-1:0] mram [NTAPS];
  bit            mknown [NTAPS];
  logic [TW-1:0] snap [NTAPS];
  logic [TW-1:0] exp_tap = '0;
  logic [TW-1:0] exp_rdata = '0;
  bit            exp_busy = 0, exp_done = 0, exp_tap_wr = 0, exp_rd_known = 0;
  bit            exp_valid = 0;

  always @(posedge clk) begin
    if (i_reset) begin
      active       = 0;
      exp_busy     = 0;
      exp_done     = 0;
      exp_tap_wr   = 0;
      exp_tap      = '0;
      exp_rdata    = '0;
      exp_rd_known = 1;
      exp_valid    = 1;
    end else begin
      busy_now = active && (cyc >= c0 + 1) && (cyc <= c0 + NTAPS + 1);
      if (int'(i_addr) < NTAPS) begin
        exp_rdata    = mram[i_addr];
        exp_rd_known = mknown[i_addr];
      end else begin
        exp_rdata    = '0;
        exp_rd_known = 1;
      end
      if (i_wr && !busy_now && int'(i_addr) < NTAPS) begin
        mram[i_addr]   = i_data;
        mknown[i_addr] = 1;
      end
      if (i_commit && !busy_now) begin
        c0     = cyc;
        active = 1;
        for (int j = 0; j < NTAPS; j++) snap[j] = mram[NTAPS-1-j];
      end
      n          = cyc + 1;
      exp_busy   = active && (n >= c0 + 1) && (n <= c0 + NTAPS + 1);
      exp_tap_wr = active && (n >= c0 + 2) && (n <= c0 + NTAPS + 1);
      if (exp_tap_wr) exp_tap = snap[n - c0 - 2];
      exp_done   = active && (n == c0 + NTAPS + 2);
    end
    cyc++;
  end

  // Downstream FIR tap chain: each strobe shifts the chain, newest at index 0.
  logic [TW-1:0] chain [NTAPS];
  always @(posedge clk) begin
    if (o_tap_wr) begin
      for (int i = NTAPS - 1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= o_tap;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (exp_valid) begin
      check("cmp_busy",   o_busy,   exp_busy);
      check("cmp_done",   o_done,   exp_done);
      check("cmp_tap_wr", o_tap_wr, exp_tap_wr);
      check("cmp_tap",    o_tap,    exp_tap);
      if (exp_rd_known) check("cmp_rdata", o_rdata, exp_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit r, input bit w, input logic [LG-1:0] a,
                       input logic [TW-1:0] d, input bit c);
    i_reset  = r;
    i_wr     = w;
    i_addr   = a;
    i_data   = d;
    i_commit = c;
    @(posedge clk);
    #1;
    i_reset  = 0;
    i_wr     = 0;
    i_commit = 0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 0, i_addr, i_data, 0);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (o_busy && t < 40) begin
      idle(1);
      t++;
    end
    check(name, o_busy, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [TW-1:0] tap_log[$];
  int first_wr, wr_cnt, done_t, done_cnt, t;
  bit got_done;
  logic [TW-1:0] exp_seq [NTAPS];

  initial begin
    drive(1, 0, '0, '0, 0);
    drive(1, 0, '0, '0, 0);

    // Idle outputs after reset
    for (int i = 0; i < 10; i++) begin
      check("idle_busy", o_busy, 0);
      check("idle_tap_wr", o_tap_wr, 0);
      check("idle_done", o_done, 0);
      check("idle_tap", o_tap, 0);
      idle(1);
    end

    // Directed burst: RAM[k] = k+1
    for (int k = 0; k < NTAPS; k++) drive(0, 1, LG'(k), TW'(k + 1), 0);
    drive(0, 0, '0, '0, 1);
    check("d1_busy_c1", o_busy, 1);
    check("d1_tapwr_c1", o_tap_wr, 0);
    first_wr = -1; wr_cnt = 0; done_t = -1; done_cnt = 0;
    tap_log.delete();
    for (int tt = 2; tt <= 12; tt++) begin
      idle(1);
      if (o_tap_wr) begin
        if (first_wr < 0) first_wr = tt;
        wr_cnt++;
        tap_log.push_back(o_tap);
      end
      if (o_done) begin
        done_t = tt;
        done_cnt++;
      end
    end
    check("d1_first_wr", first_wr, 2);
    check("d1_wr_cnt", wr_cnt, 8);
    check("d1_done_t", done_t, 10);
    check("d1_done_cnt", done_cnt, 1);
    exp_seq = '{12'd8, 12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1};
    for (int j = 0; j < NTAPS; j++)
      check("d1_seq", (j < tap_log.size()) ? tap_log[j] : 12'hfff, exp_seq[j]);
    for (int i = 0; i < NTAPS; i++) check("fir_impulse", chain[i], i + 1);

    // Mid-burst write and commit dropped; commit in o_done cycle accepted
    drive(0, 0, '0, '0, 1);
    idle(1);
    drive(0, 1, LG'(3), 12'haaa, 1);
    t = 3; got_done = 0;
    while (t < 30) begin
      if (o_done) begin
        got_done = 1;
        break;
      end
      idle(1);
      t++;
    end
    check("d2_got_done", got_done, 1);
    check("d2_done_t", t, 10);
    drive(0, 0, '0, '0, 1);
    check("d2_busy_d1", o_busy, 1);
    check("d2_tapwr_d1", o_tap_wr, 0);
    idle(1);
    check("d2_tapwr_d2", o_tap_wr, 1);
    check("d2_tap_d2", o_tap, 8);
    wait_idle("d2_idle_to");
    drive(0, 0, LG'(3), '0, 0);
    check("d2_rdback", o_rdata, 4);
    drive(0, 0, LG'(12), '0, 0);
    check("d2_rd_oor", o_rdata, 0);

    // Same-cycle write and commit
    drive(0, 1, LG'(7), 12'h123, 1);
    idle(1);
    check("d3_tapwr", o_tap_wr, 1);
    check("d3_first_tap", o_tap, 12'h123);
    wait_idle("d3_idle_to");

    // Reset mid-burst at c0+4
    drive(0, 0, '0, '0, 1);
    idle(3);
    drive(1, 0, '0, '0, 0);
    check("d4_tapwr", o_tap_wr, 0);
    check("d4_busy", o_busy, 0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (o_done) done_cnt++;
      idle(1);
    end
    check("d4_no_done", done_cnt, 0);
    drive(0, 0, '0, '0, 1);
    wait_idle("d4_idle_to");

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0)
        drive(1, 0, LG'($urandom_range(0, 15)), '0, 0);
      else
        drive(0, $urandom_range(0, 2) == 0, LG'($urandom_range(0, 15)),
              TW'($urandom), $urandom_range(0, 19) == 0);
    end
    idle(NTAPS + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
